// File: rtl/square_wave_meter_pkg.sv
// Shared definitions for the square-wave high/low/period meter:
// FSM state encoding and the default phase-counter width.
package square_wave_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } swm_state_e;

    localparam int unsigned SWM_DEFAULT_W = 16;

endpackage

// File: rtl/edge_detect.sv
// Registers the sampled input and flags rising/falling transitions.
// Edges are suppressed until one real sample has been taken after reset.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q, d_d;
    logic primed_q, primed_d;

    always_comb begin
        d_d      = d;
        primed_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q      <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            d_q      <= d_d;
            primed_q <= primed_d;
        end
    end

    // A level already high at reset release is not an edge until seen low.
    assign rise = primed_q & d & ~d_q;
    assign fall = primed_q & ~d & d_q;

endmodule

// File: rtl/square_wave_meter.sv
// Measures the high-phase and low-phase lengths of a square wave in clk
// cycles and reports them, plus their sum, once per complete period.
module square_wave_meter
    import square_wave_meter_pkg::*;
#(
    parameter int unsigned W = SWM_DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         wv_in,
    output logic [W-1:0] high_len,
    output logic [W-1:0] low_len,
    output logic [W:0]   period,
    output logic         meas_valid,
    output logic         ovf
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    swm_state_e   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cap_high_q, cap_high_d;
    logic [W-1:0] high_len_q, high_len_d;
    logic [W-1:0] low_len_q, low_len_d;
    logic [W:0]   period_q, period_d;
    logic         meas_valid_q, meas_valid_d;
    logic         ovf_q, ovf_d;

    logic         rise, fall;
    logic [W-1:0] cnt_inc;

    edge_detect u_edge_detect (
        .clk   (clk),
        .reset (reset),
        .d     (wv_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_high_d   = cap_high_q;
        high_len_d   = high_len_q;
        low_len_d    = low_len_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        ovf_d        = ovf_q;

        if (!en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            cap_high_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        cap_high_d = cnt_q;
                        cnt_d      = CNT_ONE;
                        state_d    = LOW;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        high_len_d   = cap_high_q;
                        low_len_d    = cnt_q;
                        period_d     = {1'b0, cap_high_q} + {1'b0, cnt_q};
                        meas_valid_d = 1'b1;
                        cnt_d        = CNT_ONE;
                        state_d      = HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (cnt_d == CNT_MAX) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cap_high_q   <= '0;
            high_len_q   <= '0;
            low_len_q    <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_high_q   <= cap_high_d;
            high_len_q   <= high_len_d;
            low_len_q    <= low_len_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign high_len   = high_len_q;
    assign low_len    = low_len_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_square_wave_meter.sv
// Self-checking bench: two meters (W=16, W=8) see the same wave and are
// compared every cycle against a timestamp-based model of the phase lengths.
module tb_square_wave_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        wv_in;

    logic [15:0] hl16, ll16;
    logic [16:0] per16;
    logic        mv16, ovf16;
    logic [7:0]  hl8, ll8;
    logic [8:0]  per8;
    logic        mv8, ovf8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    square_wave_meter #(.W(16)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .wv_in      (wv_in),
        .high_len   (hl16),
        .low_len    (ll16),
        .period     (per16),
        .meas_valid (mv16),
        .ovf        (ovf16)
    );

    square_wave_meter #(.W(8)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .wv_in      (wv_in),
        .high_len   (hl8),
        .low_len    (ll8),
        .period     (per8),
        .meas_valid (mv8),
        .ovf        (ovf8)
    );

    // Reference model: phase lengths are differences of edge timestamps.
    int unsigned cyc = 0, t_rise = 0, t_fall = 0;
    int unsigned m_high = 0, m_low = 0, m_peak = 0, len;
    bit armed = 0, prev = 0, in_high = 0, in_low = 0, m_valid = 0;
    bit rise_e, fall_e;

    always @(posedge clk) begin
        cyc++;
        m_valid = 1'b0;
        if (reset) begin
            armed = 0; prev = 0; in_high = 0; in_low = 0;
            m_high = 0; m_low = 0; m_peak = 0;
        end else begin
            rise_e = armed && (wv_in == 1'b1) && !prev;
            fall_e = armed && (wv_in == 1'b0) && prev;
            armed  = 1;
            prev   = wv_in;
            if (!en) begin
                in_high = 0; in_low = 0;
            end else if (in_low && rise_e) begin
                m_high  = t_fall - t_rise;
                m_low   = cyc - t_fall;
                m_valid = 1'b1;
                in_low  = 0; in_high = 1; t_rise = cyc;
            end else if (!in_high && !in_low && rise_e) begin
                in_high = 1; t_rise = cyc;
            end else if (in_high && fall_e) begin
                in_high = 0; in_low = 1; t_fall = cyc;
            end else if (in_high || in_low) begin
                len = cyc - (in_high ? t_rise : t_fall) + 1;
                if (len > m_peak) m_peak = len;
            end
        end
    end

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    logic [50:0] exp16, act16;
    logic [26:0] exp8, act8;

    always_comb begin
        exp16 = {16'(sat(m_high, 65535)), 16'(sat(m_low, 65535)),
                 17'(sat(m_high, 65535) + sat(m_low, 65535)), m_valid, m_peak >= 65535};
        exp8  = {8'(sat(m_high, 255)), 8'(sat(m_low, 255)),
                 9'(sat(m_high, 255) + sat(m_low, 255)), m_valid, m_peak >= 255};
    end

    assign act16 = {hl16, ll16, per16, mv16, ovf16};
    assign act8  = {hl8, ll8, per8, mv8, ovf8};

    task automatic step(input logic w);
        wv_in = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic w);
        reset = 1'b1;
        step(w);
        step(w);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        step(1'b1);
        step(1'b1);
        if (act16 !== '0 || act8 !== '0) begin
            errors++;
            $display("FAIL reset_state got %h/%h exp 0/0", act16, act8);
        end
        checks++;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            if (act16 !== exp16 || mv16 !== 1'b0) begin
                errors++;
                $display("FAIL reset_high_hold cyc=%0d got %h exp %h", i, act16, exp16);
            end
            checks++;
        end
    endtask

    task automatic test_periodic(input int hi, input int lo, input int reps,
                                 input int eh, input int el, input string name);
        bit q[$];
        int nvalid = 0;
        int last_v = 0;
        for (int i = 0; i < 3; i++) q.push_back(1'b0);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) q.push_back(1'b1);
            for (int i = 0; i < lo; i++) q.push_back(1'b0);
        end
        q.push_back(1'b1);
        en = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i]);
            if (act16 !== exp16) begin
                errors++;
                $display("FAIL %s_w16 idx=%0d got %h exp %h", name, i, act16, exp16);
            end
            checks++;
            if (act8 !== exp8) begin
                errors++;
                $display("FAIL %s_w8 idx=%0d got %h exp %h", name, i, act8, exp8);
            end
            checks++;
            if (mv16) begin
                nvalid++;
                if (hl16 !== 16'(eh) || ll16 !== 16'(el) || per16 !== 17'(eh + el)) begin
                    errors++;
                    $display("FAIL %s_values got %0d/%0d/%0d exp %0d/%0d/%0d",
                             name, hl16, ll16, per16, eh, el, eh + el);
                end
                checks++;
                if (nvalid == 1 && i != 3 + hi + lo) begin
                    errors++;
                    $display("FAIL %s_first_valid idx got %0d exp %0d", name, i, 3 + hi + lo);
                end
                if (nvalid > 1 && i - last_v != hi + lo) begin
                    errors++;
                    $display("FAIL %s_spacing got %0d exp %0d", name, i - last_v, hi + lo);
                end
                checks++;
                last_v = i;
            end
        end
        if (nvalid != reps) begin
            errors++;
            $display("FAIL %s_count got %0d exp %0d", name, nvalid, reps);
        end
        checks++;
    endtask

    task automatic test_overflow();
        bit q[$];
        int nvalid = 0;
        for (int i = 0; i < 3; i++) q.push_back(1'b0);
        for (int i = 0; i < 300; i++) q.push_back(1'b1);
        for (int i = 0; i < 10; i++) q.push_back(1'b0);
        q.push_back(1'b1);
        for (int i = 0; i < 3; i++) q.push_back(1'b0);
        en = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i]);
            if (act16 !== exp16 || act8 !== exp8) begin
                errors++;
                $display("FAIL ovf_track idx=%0d got %h/%h exp %h/%h", i, act16, act8, exp16, exp8);
            end
            checks++;
            if (mv8) begin
                nvalid++;
                if (hl8 !== 8'd255 || ll8 !== 8'd10 || per8 !== 9'd265 || ovf8 !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_w8_values got %0d/%0d/%0d ovf=%b exp 255/10/265 ovf=1",
                             hl8, ll8, per8, ovf8);
                end
                checks++;
                if (hl16 !== 16'd300 || per16 !== 17'd310 || ovf16 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_w16_values got %0d/%0d ovf=%b exp 300/310 ovf=0",
                             hl16, per16, ovf16);
                end
                checks++;
            end
        end
        if (nvalid != 1 || ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got valids=%0d ovf=%b exp 1 1", nvalid, ovf8);
        end
        checks++;
    endtask

    task automatic test_reset_mid_high();
        bit q[$];
        int nvalid = 0;
        en = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        do_reset(1'b1);
        if (act16 !== '0 || act8 !== '0) begin
            errors++;
            $display("FAIL midreset_zero got %h/%h exp 0/0", act16, act8);
        end
        checks++;
        for (int i = 0; i < 15; i++) q.push_back(1'b1);
        for (int i = 0; i < 30; i++) q.push_back(1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 25; i++) q.push_back(1'b1);
            for (int i = 0; i < 30; i++) q.push_back(1'b0);
        end
        q.push_back(1'b1);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i]);
            if (act16 !== exp16) begin
                errors++;
                $display("FAIL midreset_track idx=%0d got %h exp %h", i, act16, exp16);
            end
            checks++;
            if (mv16) begin
                nvalid++;
                if (nvalid == 1 && (i != 45 + 55 || hl16 !== 16'd25 || ll16 !== 16'd30 || per16 !== 17'd55)) begin
                    errors++;
                    $display("FAIL midreset_first idx=%0d got %0d/%0d/%0d exp idx=100 25/30/55",
                             i, hl16, ll16, per16);
                end
                checks++;
            end
        end
    endtask

    task automatic test_en_drop();
        int nvalid = 0;
        int idx = 0;
        bit q[$];
        en = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 25; i++) step(1'b1);
            for (int i = 0; i < (r == 0 ? 30 : 12); i++) step(1'b0);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            if (mv16 !== 1'b0 || hl16 !== 16'd25 || ll16 !== 16'd30 || per16 !== 17'd55) begin
                errors++;
                $display("FAIL en_drop_hold cyc=%0d got v=%b %0d/%0d/%0d exp v=0 25/30/55",
                         i, mv16, hl16, ll16, per16);
            end
            checks++;
        end
        en = 1'b1;
        for (int i = 0; i < 15; i++) q.push_back(1'b0);
        for (int i = 0; i < 20; i++) q.push_back(1'b1);
        for (int i = 0; i < 35; i++) q.push_back(1'b0);
        q.push_back(1'b1);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i]);
            idx = i;
            if (act16 !== exp16) begin
                errors++;
                $display("FAIL en_resume_track idx=%0d got %h exp %h", i, act16, exp16);
            end
            checks++;
            if (mv16) begin
                nvalid++;
                if (i != 70 || hl16 !== 16'd20 || ll16 !== 16'd35 || per16 !== 17'd55) begin
                    errors++;
                    $display("FAIL en_resume_meas idx=%0d got %0d/%0d/%0d exp idx=70 20/35/55",
                             i, hl16, ll16, per16);
                end
                checks++;
            end
        end
        if (nvalid != 1) begin
            errors++;
            $display("FAIL en_resume_count got %0d exp 1 (last idx %0d)", nvalid, idx);
        end
        checks++;
    endtask

    task automatic test_random();
        logic w = 1'b0;
        int plen;
        en = 1'b1;
        do_reset(1'b0);
        for (int p = 0; p < 80; p++) begin
            plen = int'($urandom_range(1, 40));
            for (int i = 0; i < plen; i++) begin
                en = ($urandom_range(0, 99) != 0);
                step(w);
                if (act16 !== exp16) begin
                    errors++;
                    $display("FAIL random_w16 phase=%0d got %h exp %h", p, act16, exp16);
                end
                checks++;
                if (act8 !== exp8) begin
                    errors++;
                    $display("FAIL random_w8 phase=%0d got %h exp %h", p, act8, exp8);
                end
                checks++;
            end
            w = ~w;
        end
        en = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        wv_in = 1'b0;
        test_reset();
        test_periodic(25, 30, 3, 25, 30, "gen_m5_n6");
        test_periodic(5, 5, 4, 5, 5, "gen_m1_n1");
        test_periodic(1, 2, 5, 1, 2, "hi1_lo2");
        test_overflow();
        test_reset_mid_high();
        test_en_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
